// File: rtl/sprod_accum_pkg.sv
// Shared definitions for the signed product accumulator.
// Contents: the FSM state encoding and the saturation bounds for a given data width.
package sprod_accum_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Returned at 64 bits; callers keep the low w bits (w <= 64).
    function automatic logic signed [63:0] sat_max(input int w);
        return (64'sd1 <<< (w - 1)) - 64'sd1;
    endfunction

    function automatic logic signed [63:0] sat_min(input int w);
        return -(64'sd1 <<< (w - 1));
    endfunction

endpackage

// File: rtl/sat_add.sv
// Combinational signed saturating adder.
// It clamps to MAX/MIN and flags ovf when the exact sum does not fit in DATAWIDTH bits.
module sat_add
    import sprod_accum_pkg::*;
#(
    parameter int DATAWIDTH = 64
) (
    input  logic signed [DATAWIDTH-1:0] a,
    input  logic signed [DATAWIDTH-1:0] b,
    output logic signed [DATAWIDTH-1:0] sum,
    output logic                        ovf
);

    localparam logic signed [63:0] MAX_W = sat_max(DATAWIDTH);
    localparam logic signed [63:0] MIN_W = sat_min(DATAWIDTH);
    localparam logic signed [DATAWIDTH-1:0] MAX_V = MAX_W[DATAWIDTH-1:0];
    localparam logic signed [DATAWIDTH-1:0] MIN_V = MIN_W[DATAWIDTH-1:0];

    logic signed [DATAWIDTH:0] wide;

    // The add is one bit wider than the data; top two bits disagreeing means overflow.
    always_comb begin
        wide = {a[DATAWIDTH-1], a} + {b[DATAWIDTH-1], b};
        sum  = wide[DATAWIDTH-1:0];
        ovf  = 1'b0;
        if (wide[DATAWIDTH] != wide[DATAWIDTH-1]) begin
            ovf = 1'b1;
            sum = wide[DATAWIDTH] ? MIN_V : MAX_V;
        end
    end

endmodule

// File: rtl/sprod_accum.sv
// Signed product accumulator: sums a run of len products with saturation.
// It presents the final sum and a sticky overflow flag over a valid/ready handshake.
module sprod_accum
    import sprod_accum_pkg::*;
#(
    parameter int DATAWIDTH = 64,
    parameter int CNTWIDTH  = 8
) (
    input  logic                        Clk,
    input  logic                        Rst,
    input  logic                        start,
    input  logic [CNTWIDTH-1:0]         len,
    input  logic signed [DATAWIDTH-1:0] prod,
    input  logic                        prod_valid,
    output logic                        prod_ready,
    output logic signed [DATAWIDTH-1:0] sum,
    output logic                        sum_valid,
    input  logic                        sum_ready,
    output logic                        ovf,
    output logic                        busy
);

    localparam logic [CNTWIDTH-1:0] CNT_ONE = CNTWIDTH'(1);

    state_t                      state_q;
    logic signed [DATAWIDTH-1:0] acc_q;
    logic signed [DATAWIDTH-1:0] acc_d;
    logic [CNTWIDTH-1:0]         rem_q;
    logic                        ovf_q;
    logic                        sat_d;
    logic                        prod_ready_q;
    logic                        sum_valid_q;
    logic                        busy_q;

    sat_add #(
        .DATAWIDTH(DATAWIDTH)
    ) u_sat_add (
        .a  (acc_q),
        .b  (prod),
        .sum(acc_d),
        .ovf(sat_d)
    );

    // Handshake outputs are registered alongside the state so they change only on the clock edge.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q      <= IDLE;
            acc_q        <= '0;
            rem_q        <= '0;
            ovf_q        <= 1'b0;
            prod_ready_q <= 1'b0;
            sum_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        acc_q  <= '0;
                        ovf_q  <= 1'b0;
                        rem_q  <= len;
                        busy_q <= 1'b1;
                        if (len == '0) begin
                            state_q     <= DONE;
                            sum_valid_q <= 1'b1;
                        end else begin
                            state_q      <= ACCUM;
                            prod_ready_q <= 1'b1;
                        end
                    end
                end
                ACCUM: begin
                    if (prod_valid) begin
                        acc_q <= acc_d;
                        ovf_q <= ovf_q | sat_d;
                        rem_q <= rem_q - CNT_ONE;
                        if (rem_q == CNT_ONE) begin
                            state_q      <= DONE;
                            prod_ready_q <= 1'b0;
                            sum_valid_q  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (sum_ready) begin
                        state_q     <= IDLE;
                        sum_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                    end
                end
                default: begin
                    state_q      <= IDLE;
                    prod_ready_q <= 1'b0;
                    sum_valid_q  <= 1'b0;
                    busy_q       <= 1'b0;
                end
            endcase
        end
    end

    assign prod_ready = prod_ready_q;
    assign sum_valid  = sum_valid_q;
    assign busy       = busy_q;
    assign sum        = acc_q;
    assign ovf        = ovf_q;

endmodule

// File: tb/tb_sprod_accum.sv
// Scoreboard bench for sprod_accum at DATAWIDTH=8, CNTWIDTH=4.
// Directed runs push expected results; a negedge monitor pops and compares on each result handshake.
module tb_sprod_accum;

    typedef struct packed {
        logic signed [7:0] s;
        logic              o;
    } exp_t;

    logic              Clk = 1'b0;
    logic              Rst = 1'b1;
    logic              start = 1'b0;
    logic [3:0]        len = '0;
    logic signed [7:0] prod = '0;
    logic              prod_valid = 1'b0;
    logic              prod_ready;
    logic signed [7:0] sum;
    logic              sum_valid;
    logic              sum_ready = 1'b1;
    logic              ovf;
    logic              busy;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    sprod_accum #(
        .DATAWIDTH(8),
        .CNTWIDTH (4)
    ) dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .start     (start),
        .len       (len),
        .prod      (prod),
        .prod_valid(prod_valid),
        .prod_ready(prod_ready),
        .sum       (sum),
        .sum_valid (sum_valid),
        .sum_ready (sum_ready),
        .ovf       (ovf),
        .busy      (busy)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic send(input logic signed [7:0] p);
        prod       = p;
        prod_valid = 1'b1;
        tick();
        prod_valid = 1'b0;
    endtask

    task automatic begin_run(input logic [3:0] l, input logic signed [7:0] es, input logic eo);
        exp_t e;
        e.s = es;
        e.o = eo;
        exp_q.push_back(e);
        start = 1'b1;
        len   = l;
        tick();
        start = 1'b0;
    endtask

    // Result monitor: compares every accepted result against the scoreboard head.
    always @(negedge Clk) begin
        if (!Rst && sum_valid && sum_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_result", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("sb_sum", int'(sum), int'(e.s));
                check("sb_ovf", int'(ovf), int'(e.o));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset values
        #12;
        check("rst_sum", int'(sum), 0);
        check("rst_sum_valid", int'(sum_valid), 0);
        check("rst_prod_ready", int'(prod_ready), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_ovf", int'(ovf), 0);
        tick();
        Rst = 1'b0;
        tick();

        // Basic run: 5 - 2 + 10 = 13
        check("idle_busy", int'(busy), 0);
        begin_run(4'd3, 8'sd13, 1'b0);
        check("start_busy", int'(busy), 1);
        check("start_prod_ready", int'(prod_ready), 1);
        send(8'sd5);
        send(-8'sd2);
        check("mid_sum_valid", int'(sum_valid), 0);
        send(8'sd10);
        check("basic_latency", int'(sum_valid), 1);
        check("basic_prod_ready", int'(prod_ready), 0);
        tick();
        check("basic_idle", int'(busy), 0);

        // Positive saturation: 100 + 100 -> 127
        begin_run(4'd2, 8'sd127, 1'b1);
        send(8'sd100);
        send(8'sd100);
        check("satp_valid", int'(sum_valid), 1);
        tick();

        // Negative saturation then recovery: -128 + 50 = -78, ovf sticky
        begin_run(4'd3, -8'sd78, 1'b1);
        send(-8'sd100);
        send(-8'sd100);
        send(8'sd50);
        check("satn_valid", int'(sum_valid), 1);
        tick();

        // Gaps and back-pressure: beats 1,2,3,4 with bubbles -> 10
        sum_ready = 1'b0;
        begin_run(4'd4, 8'sd10, 1'b0);
        send(8'sd1);
        prod = 8'sd99; tick();
        send(8'sd2);
        prod = 8'sd99; tick();
        check("gap_not_done", int'(sum_valid), 0);
        send(8'sd3);
        send(8'sd4);
        for (int i = 0; i < 5; i++) begin
            check("bp_sum_valid", int'(sum_valid), 1);
            check("bp_sum", int'(sum), 10);
            check("bp_prod_ready", int'(prod_ready), 0);
            tick();
        end
        sum_ready = 1'b1;
        tick();
        check("bp_released", int'(sum_valid), 0);

        // Zero length
        begin_run(4'd0, 8'sd0, 1'b0);
        check("zero_valid", int'(sum_valid), 1);
        check("zero_sum", int'(sum), 0);
        tick();

        // Start during ACCUM is ignored: 3 + 4 = 7 after exactly 2 beats
        begin_run(4'd2, 8'sd7, 1'b0);
        start = 1'b1;
        len   = 4'd5;
        send(8'sd3);
        start = 1'b0;
        send(8'sd4);
        check("ign_start_done", int'(sum_valid), 1);
        check("ign_start_sum", int'(sum), 7);
        tick();

        // Asynchronous reset mid-run after two saturating beats
        start = 1'b1;
        len   = 4'd5;
        tick();
        start = 1'b0;
        send(8'sd100);
        send(8'sd100);
        check("pre_rst_ovf", int'(ovf), 1);
        #2;
        Rst = 1'b1;
        #1;
        check("arst_sum", int'(sum), 0);
        check("arst_busy", int'(busy), 0);
        check("arst_prod_ready", int'(prod_ready), 0);
        check("arst_sum_valid", int'(sum_valid), 0);
        check("arst_ovf", int'(ovf), 0);
        tick();
        tick();
        Rst = 1'b0;
        tick();

        // Fresh run after reset
        begin_run(4'd1, -8'sd7, 1'b0);
        send(-8'sd7);
        check("post_rst_valid", int'(sum_valid), 1);
        tick();
        tick();
        check("sb_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sprod_accum.md
# sprod_accum

Signed product accumulator that sits directly downstream of the signed multiplier (SMUL) in generated datapaths. It takes a run of `len` signed products over a valid/ready handshake and adds them into a saturating signed accumulator. It then presents the final sum, with a sticky overflow flag, over a second valid/ready handshake. Together with SMUL it forms a multi-cycle dot-product / multiply-accumulate stage.

## Interface
- `DATAWIDTH`, 64, width of the incoming product and of the outgoing sum (signed two's complement).
- `CNTWIDTH`, 8, width of the run-length field; a run holds at most 2^CNTWIDTH-1 products.

Ports:
- `Clk` input 1 — single clock; all state updates on rising edge.
- `Rst` input 1 — asynchronous, active-high reset.
- `start` input 1 — begin a run; honoured only in IDLE.
- `len` input CNTWIDTH — number of products in the run, sampled with `start`.
- `prod` input DATAWIDTH signed — product from SMUL.
- `prod_valid` input 1 — `prod` is valid.
- `prod_ready` output 1 — block accepts `prod` this cycle.
- `sum` output DATAWIDTH signed — accumulated result (registered).
- `sum_valid` output 1 — `sum` and `ovf` are final.
- `sum_ready` input 1 — consumer takes `sum`.
- `ovf` output 1 — sticky: saturation occurred at least once in the current run.
- `busy` output 1 — high whenever state is not IDLE.

## Operation
- FSM has three states: IDLE, ACCUM, DONE.
- **IDLE:** `prod_ready=0`, `sum_valid=0`.
  - On `start`: clear the accumulator to 0, clear `ovf`, and load `remaining=len`.
  - If `len==0`, go to DONE; otherwise go to ACCUM.
- **ACCUM:** `prod_ready=1`.
  - A beat is accepted at an edge where `prod_valid & prod_ready`.
  - On each accepted beat: accumulator ← sat(acc + prod); `remaining` decrements.
  - When the accepted beat has `remaining==1`, go to DONE.
  - Cycles with `prod_valid=0` hold all state.
- **DONE:** `sum_valid=1`, `prod_ready=0`; `sum` and `ovf` are held stable.
  - At an edge with `sum_ready=1`, go to IDLE.
- Arithmetic: the add is computed at DATAWIDTH+1 bits.
  - Result > 2^(DATAWIDTH-1)-1 → clamp to MAX and set `ovf`.
  - Result < -2^(DATAWIDTH-1) → clamp to MIN and set `ovf`.
  - Otherwise the result is exact. `ovf` never clears mid-run.
- `sum` always reflects the accumulator register, so it is visible (but not valid) during ACCUM.
- `start` outside IDLE is ignored; `len` is not re-sampled.

## Timing
- Reset values: state=IDLE, accumulator/`sum`=0, `remaining`=0, `ovf`=0, `prod_ready`=0, `sum_valid`=0, `busy`=0.
- `start` sampled at edge k → `busy` and `prod_ready` high from k+1.
- Last beat accepted at edge m → `sum_valid=1` from m+1 with the final sum. Latency from last beat to result is one cycle.
- Throughput in ACCUM is one product per cycle; there are no bubbles while `prod_valid` stays high.
- `len==0`: `start` at edge k → `sum_valid=1`, `sum=0` from k+1.
- Result handshake at edge n → IDLE from n+1. A `start` held during cycle n is ignored; the earliest new `start` is accepted at edge n+1. Minimum run turnaround is len+2 cycles.
- `Rst` asserted at any time, including mid-run or during DONE: immediate return to reset values. The partial sum is discarded and no `sum_valid` pulse is produced.
- Back-pressure: `sum_ready=0` holds DONE indefinitely, with `sum` and `ovf` stable.

## Structure
- Package `sprod_accum_pkg` holds:
  - the state encoding constants: IDLE=2'd0, ACCUM=2'd1, DONE=2'd2;
  - MAX/MIN saturation constant functions of DATAWIDTH.
- Sub-module `sat_add`: combinational signed saturating adder (DATAWIDTH param; outputs `sum`, `ovf`). It is reusable by other generated accumulating stages.
- Top level holds the FSM, the `remaining` counter, the accumulator register and the sticky `ovf`.

## Test plan
Bench uses DATAWIDTH=8, CNTWIDTH=4.
- **Basic run:** reset, `start` with `len=3`, products 5, -2, 10 back-to-back → `sum_valid` one cycle after the third beat, `sum=13`, `ovf=0`, `busy` high from the cycle after `start`.
- **Saturation:** `len=2`, products 100, 100 → `sum=127`, `ovf=1`. Negative case: `len=3`, products -100, -100, 50 → `sum=-78` (clamped -128 then +50), `ovf=1`.
- **Gaps and back-pressure:** `len=4` with `prod_valid` toggling 1,0,1,0,1,1; hold `sum_ready=0` for 5 cycles → only 4 beats counted, and `sum`/`sum_valid` stay stable until `sum_ready` rises.
- **Zero length and ignored start:** `start` with `len=0` → next cycle `sum_valid=1`, `sum=0`. A second `start` pulsed during ACCUM of another run → no effect on `remaining` or `sum`.
- **Reset mid-run:** assert `Rst` asynchronously after 2 of 5 beats → outputs return to reset values immediately with no `sum_valid`. A fresh `len=1` run with product -7 then yields `sum=-7`, `ovf=0`.
